snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Game-control block for the snake game. It runs the START/PLAY/END state machine, detects when the head eats an apple, and places each new apple using a free-running LFSR. It produces the `Game_status`, `Body_add_sig` and `Apple_type` signals that the seven-segment score display consumes, plus the apple position used by the VGA renderer.

## Interface
Parameters:
- `GRID_W`, 40: playfield width in cells, must be ≤ 64.
- `GRID_H`, 30: playfield height in cells, must be ≤ 32.
- `GREEN_EVERY`, 5: every GREEN_EVERY-th apple is green.
- `LFSR_SEED`, 16'hACE1: LFSR reset value, must be non-zero.

Ports:
- `Clk_50mhz`  in  1  50 MHz system clock.
- `Rst`  in  1  reset, asynchronous, active-high.
- `Key_start`  in  1  debounced, synchronous start key (level).
- `Move_tick`  in  1  one-cycle pulse when the snake head advances.
- `Head_x`  in  6  head column, valid on `Move_tick`.
- `Head_y`  in  5  head row, valid on `Move_tick`.
- `Hit_sig`  in  1  wall or body collision, valid on `Move_tick`.
- `Game_status`  out  3  one-hot state: START=001, PLAY=010, END=100.
- `Body_add_sig`  out  1  one-cycle pulse per apple eaten.
- `Apple_type`  out  1  type of the current apple: 0 red, 1 green.
- `Apple_x`  out  6  apple column.
- `Apple_y`  out  5  apple row.

## Operation
- **Key edge:** `key_q` registers `Key_start`. A press is `Key_start & ~key_q`.
- **FSM (registered, one-hot):**
  - START → PLAY on a press.
  - PLAY → END on `Move_tick & Hit_sig`.
  - END → START on a press.
  - No other transitions. A press in PLAY is ignored.
- **Entering PLAY:**
  - eat counter `eat_cnt` cleared to 0.
  - apple set to (GRID_W−10, GRID_H/2).
  - `Apple_type` set to 0.
- **Eat:** occurs in PLAY when `Move_tick & ~Hit_sig & Head_x==Apple_x & Head_y==Apple_y`.
- **Hit priority:** if hit and eat coincide, the hit wins. The FSM goes to END and there is no pulse.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. It shifts every cycle in every state.
- **New apple (after an eat):**
  - x = `lfsr[5:0]`; if x ≥ GRID_W, subtract GRID_W.
  - y = `lfsr[12:8]`; if y ≥ GRID_H, subtract GRID_H.
  - If the new position equals the head position, add 1 to x, wrapping to 0 at GRID_W.
  - The block does not check for overlap with the body.
- **eat_cnt:** range 0..GREEN_EVERY−1, increments on each eat and wraps to 0. The next `Apple_type` = (new eat_cnt == GREEN_EVERY−1).
- **START and END:** apple position and type hold. `Body_add_sig` stays 0.

## Timing
- **Reset values:**
  - `Game_status` = 001
  - `Body_add_sig` = 0
  - `Apple_type` = 0
  - `Apple_x` = GRID_W−10, `Apple_y` = GRID_H/2
  - lfsr = LFSR_SEED
  - eat_cnt = 0, key_q = 0
- **Status latency:** `Game_status` changes on the edge after the qualifying press or `Move_tick`, i.e. 1 cycle.
- **Eat sequence:**
  - Cycle T: `Move_tick` eat condition.
  - Cycle T+1: `Body_add_sig` = 1 for exactly one cycle. `Apple_type`, `Apple_x` and `Apple_y` still hold the eaten apple's values, so the display samples the correct type.
  - Cycle T+2: new apple position and type are visible. `Body_add_sig` = 0.
- **Consecutive ticks:** `Move_tick` pulses are at least 3 cycles apart. Behaviour with closer ticks is undefined.
- **Reset mid-operation:** asynchronous return to the reset values. A pending pulse is dropped.
- **Key held:** a key held across START→PLAY does not re-trigger, because only edges count.

## Structure
- Shared `snake_pkg`:
  - state encodings `ST_START`, `ST_PLAY`, `ST_END`
  - grid-size constants
  - LFSR tap mask
- Sub-module `apple_gen`: owns the LFSR, the fold/wrap arithmetic and eat_cnt. It takes a load-initial input and a next input, and outputs x, y and type. The FSM and eat detection stay in the top module.

## Test plan
- **Reset then press:** `Rst` pulse, then press `Key_start` → `Game_status` goes 001→010 one cycle after the edge. Apple = (30,15), `Apple_type` = 0.
- **Single eat:** in PLAY, `Move_tick` with head (30,15) and `Hit_sig` = 0 → `Body_add_sig` high for one cycle at T+1 with `Apple_type` = 0. At T+2 the apple position is within 0..39 / 0..29 and differs from (30,15)-head.
- **Fifth apple green:** perform 4 eats → after the 4th, `Apple_type` = 1. The 5th eat pulses with `Apple_type` = 1, then `Apple_type` returns to 0.
- **Hit beats eat:** `Move_tick` with head on the apple and `Hit_sig` = 1 → `Game_status` = 100, `Body_add_sig` never asserts, apple unchanged.
- **END→START:** press in END → 001. Holding the key gives no further transition. Release and press again → 010 with eat_cnt and apple reinitialised.
- **Async reset during eat:** assert `Rst` in cycle T+1 → `Body_add_sig` drops immediately, all outputs take their reset values.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game control block.
// State encodings, grid defaults and the LFSR polynomial.
package snake_pkg;

    typedef enum logic [2:0] {
        ST_START = 3'b001,
        ST_PLAY  = 3'b010,
        ST_END   = 3'b100
    } state_t;

    localparam int GRID_W_DEF      = 40;
    localparam int GRID_H_DEF      = 30;
    localparam int GREEN_EVERY_DEF = 5;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // Taps 16,14,13,11 of a left-shifting Fibonacci register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/snake_game_ctrl_apple_gen.sv
// Apple placement: free-running LFSR, fold into the grid, avoid the head,
// and count eats so that every GREEN_EVERY-th apple is green.
module apple_gen
    import snake_pkg::*;
#(
    parameter int          GRID_W      = GRID_W_DEF,
    parameter int          GRID_H      = GRID_H_DEF,
    parameter int          GREEN_EVERY = GREEN_EVERY_DEF,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_init,
    input  logic       next,
    input  logic [5:0] head_x,
    input  logic [4:0] head_y,
    output logic [5:0] x,
    output logic [4:0] y,
    output logic       apple_type
);

    localparam int CW = (GREEN_EVERY > 1) ? $clog2(GREEN_EVERY) : 1;
    localparam logic [5:0] INIT_X = 6'(GRID_W - 10);
    localparam logic [4:0] INIT_Y = 5'(GRID_H / 2);

    logic [15:0]   lfsr;
    logic [CW-1:0] eat_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [6:0]    fx7;
    logic [5:0]    fy6;
    logic [5:0]    nx;
    logic [4:0]    ny;

    // A single conditional subtract is enough because the raw fields
    // are at most twice the grid size.
    always_comb begin
        fx7 = {1'b0, lfsr[5:0]};
        if (fx7 >= 7'(GRID_W)) begin
            fx7 = fx7 - 7'(GRID_W);
        end
        fy6 = {1'b0, lfsr[12:8]};
        if (fy6 >= 6'(GRID_H)) begin
            fy6 = fy6 - 6'(GRID_H);
        end
        nx = fx7[5:0];
        ny = fy6[4:0];
        if (nx == head_x && ny == head_y) begin
            if (32'(nx) == GRID_W - 1) begin
                nx = 6'd0;
            end else begin
                nx = nx + 6'd1;
            end
        end
    end

    always_comb begin
        if (eat_cnt == CW'(GREEN_EVERY - 1)) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = eat_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr       <= LFSR_SEED;
            eat_cnt    <= '0;
            x          <= INIT_X;
            y          <= INIT_Y;
            apple_type <= 1'b0;
        end else begin
            lfsr <= lfsr_step(lfsr);
            if (load_init) begin
                eat_cnt    <= '0;
                x          <= INIT_X;
                y          <= INIT_Y;
                apple_type <= 1'b0;
            end else if (next) begin
                eat_cnt    <= cnt_nxt;
                x          <= nx;
                y          <= ny;
                apple_type <= (cnt_nxt == CW'(GREEN_EVERY - 1));
            end
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control: START/PLAY/END state machine, eat detection and
// apple placement handshake with the score display and renderer.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int          GRID_W      = GRID_W_DEF,
    parameter int          GRID_H      = GRID_H_DEF,
    parameter int          GREEN_EVERY = GREEN_EVERY_DEF,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
    input  logic       Clk_50mhz,
    input  logic       Rst,
    input  logic       Key_start,
    input  logic       Move_tick,
    input  logic [5:0] Head_x,
    input  logic [4:0] Head_y,
    input  logic       Hit_sig,
    output logic [2:0] Game_status,
    output logic       Body_add_sig,
    output logic       Apple_type,
    output logic [5:0] Apple_x,
    output logic [4:0] Apple_y
);

    state_t     state;
    logic       key_q;
    logic       press;
    logic       eat;
    logic       load_init;
    logic [5:0] head_x_q;
    logic [4:0] head_y_q;

    assign press     = Key_start & ~key_q;
    assign load_init = (state == ST_START) & press;
    assign eat       = (state == ST_PLAY) & Move_tick & ~Hit_sig &
                       (Head_x == Apple_x) & (Head_y == Apple_y);

    assign Game_status = state;

    // The head is latched at the eat so the new apple avoids the cell the
    // head occupied, even though Head_x/Head_y are only valid on the tick.
    always_ff @(posedge Clk_50mhz or posedge Rst) begin
        if (Rst) begin
            state        <= ST_START;
            key_q        <= 1'b0;
            Body_add_sig <= 1'b0;
            head_x_q     <= '0;
            head_y_q     <= '0;
        end else begin
            key_q        <= Key_start;
            Body_add_sig <= eat;
            if (eat) begin
                head_x_q <= Head_x;
                head_y_q <= Head_y;
            end
            unique case (state)
                ST_START: if (press) state <= ST_PLAY;
                ST_PLAY:  if (Move_tick && Hit_sig) state <= ST_END;
                ST_END:   if (press) state <= ST_START;
                default:  state <= ST_START;
            endcase
        end
    end

    apple_gen #(
        .GRID_W      (GRID_W),
        .GRID_H      (GRID_H),
        .GREEN_EVERY (GREEN_EVERY),
        .LFSR_SEED   (LFSR_SEED)
    ) u_apple_gen (
        .clk        (Clk_50mhz),
        .rst        (Rst),
        .load_init  (load_init),
        .next       (Body_add_sig),
        .head_x     (head_x_q),
        .head_y     (head_y_q),
        .x          (Apple_x),
        .y          (Apple_y),
        .apple_type (Apple_type)
    );

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: cycle model of the game rules compared every
// cycle, plus directed scenarios with literal expectations.
module tb_snake_game_ctrl;

    localparam int GW = 40;
    localparam int GH = 30;
    localparam int GE = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start = 1'b0;
    logic       move_tick = 1'b0;
    logic [5:0] head_x = '0;
    logic [4:0] head_y = '0;
    logic       hit = 1'b0;
    logic [2:0] game_status;
    logic       body_add;
    logic       apple_type;
    logic [5:0] apple_x;
    logic [4:0] apple_y;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .GRID_W      (GW),
        .GRID_H      (GH),
        .GREEN_EVERY (GE),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .Clk_50mhz    (clk),
        .Rst          (rst),
        .Key_start    (key_start),
        .Move_tick    (move_tick),
        .Head_x       (head_x),
        .Head_y       (head_y),
        .Hit_sig      (hit),
        .Game_status  (game_status),
        .Body_add_sig (body_add),
        .Apple_type   (apple_type),
        .Apple_x      (apple_x),
        .Apple_y      (apple_y)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---- behavioural model of the game rules ----
    int       m_status = 1;
    bit       m_key    = 0;
    bit [15:0] m_lfsr  = 16'hACE1;
    int       m_cnt    = 0;
    int       m_ax     = GW - 10;
    int       m_ay     = GH / 2;
    bit       m_type   = 0;
    bit       m_pulse  = 0;
    int       m_hx     = 0;
    int       m_hy     = 0;

    function automatic bit [15:0] lfsr_next(input bit [15:0] s);
        bit fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_status <= 1; m_key <= 0; m_lfsr <= 16'hACE1; m_cnt <= 0;
            m_ax <= GW - 10; m_ay <= GH / 2; m_type <= 0; m_pulse <= 0;
            m_hx <= 0; m_hy <= 0;
        end else begin : step
            bit pr;
            bit e;
            int nx;
            int ny;
            int nc;
            pr = key_start && !m_key;
            e  = (m_status == 2) && move_tick && !hit &&
                 (int'(head_x) == m_ax) && (int'(head_y) == m_ay);
            m_key   <= key_start;
            m_pulse <= e;
            m_lfsr  <= lfsr_next(m_lfsr);
            if (e) begin
                m_hx <= head_x;
                m_hy <= head_y;
            end
            if (m_status == 1 && pr) m_status <= 2;
            else if (m_status == 2 && move_tick && hit) m_status <= 4;
            else if (m_status == 4 && pr) m_status <= 1;
            if (m_status == 1 && pr) begin
                m_ax <= GW - 10; m_ay <= GH / 2; m_type <= 0; m_cnt <= 0;
            end else if (m_pulse) begin
                nx = int'(m_lfsr & 16'h003F) % GW;
                ny = int'((m_lfsr >> 8) & 16'h001F) % GH;
                if (nx == m_hx && ny == m_hy) nx = (nx + 1) % GW;
                nc = (m_cnt + 1) % GE;
                m_ax <= nx; m_ay <= ny; m_cnt <= nc;
                m_type <= (nc == GE - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("status", int'(game_status), m_status);
            check("body_add", int'(body_add), int'(m_pulse));
            check("apple_type", int'(apple_type), int'(m_type));
            check("apple_x", int'(apple_x), m_ax);
            check("apple_y", int'(apple_y), m_ay);
        end
    end

    // ---- directed stimulus ----
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic press();
        key_start = 1'b1;
        cyc();
        key_start = 1'b0;
        cyc();
    endtask

    task automatic tick(input int x, input int y, input bit h);
        head_x = 6'(x); head_y = 5'(y); hit = h; move_tick = 1'b1;
        cyc();
        move_tick = 1'b0; hit = 1'b0;
        repeat (3) cyc();
    endtask

    int sx;
    int sy;

    initial begin
        repeat (2) cyc();
        check("rst_status", int'(game_status), 1);
        check("rst_apple_x", int'(apple_x), 30);
        check("rst_apple_y", int'(apple_y), 15);
        check("rst_type", int'(apple_type), 0);
        check("rst_body", int'(body_add), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) cyc();

        key_start = 1'b1;
        cyc();
        check("start_play", int'(game_status), 2);
        check("play_apple_x", int'(apple_x), 30);
        check("play_apple_y", int'(apple_y), 15);
        repeat (3) cyc();
        check("held_key_play", int'(game_status), 2);
        key_start = 1'b0;
        cyc();

        // Single eat with the exact pulse timing
        head_x = 6'd30; head_y = 5'd15; move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        check("eat1_pulse", int'(body_add), 1);
        check("eat1_type", int'(apple_type), 0);
        check("eat1_hold_x", int'(apple_x), 30);
        cyc();
        check("eat1_pulse_end", int'(body_add), 0);
        check("eat1_x_range", int'(apple_x < 6'd40), 1);
        check("eat1_y_range", int'(apple_y < 5'd30), 1);
        check("eat1_ne_head", int'(apple_x != 6'd30 || apple_y != 5'd15), 1);
        repeat (2) cyc();

        // Tick away from the apple: no eat
        tick((m_ax + 1) % GW, m_ay, 1'b0);
        check("miss_status", int'(game_status), 2);

        for (int i = 2; i <= 4; i++) tick(m_ax, m_ay, 1'b0);
        check("fourth_green", int'(apple_type), 1);

        head_x = 6'(m_ax); head_y = 5'(m_ay); move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        check("eat5_pulse", int'(body_add), 1);
        check("eat5_type", int'(apple_type), 1);
        cyc();
        check("eat5_back_red", int'(apple_type), 0);
        repeat (2) cyc();

        press();
        check("press_in_play", int'(game_status), 2);
        repeat (2) cyc();

        // Hit on the apple: hit wins
        sx = m_ax; sy = m_ay;
        head_x = 6'(sx); head_y = 5'(sy); hit = 1'b1; move_tick = 1'b1;
        cyc();
        move_tick = 1'b0; hit = 1'b0;
        check("hit_end", int'(game_status), 4);
        check("hit_no_pulse", int'(body_add), 0);
        repeat (3) cyc();
        check("hit_apple_x", int'(apple_x), sx);
        check("hit_apple_y", int'(apple_y), sy);

        key_start = 1'b1;
        cyc();
        check("end_start", int'(game_status), 1);
        repeat (4) cyc();
        check("held_key_start", int'(game_status), 1);
        key_start = 1'b0;
        cyc();
        key_start = 1'b1;
        cyc();
        key_start = 1'b0;
        check("replay", int'(game_status), 2);
        check("replay_x", int'(apple_x), 30);
        check("replay_y", int'(apple_y), 15);
        check("replay_type", int'(apple_type), 0);
        repeat (2) cyc();

        // Reset asynchronously while the pulse is high
        head_x = 6'd30; head_y = 5'd15; move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        check("pre_rst_pulse", int'(body_add), 1);
        rst = 1'b1;
        #1;
        check("arst_body", int'(body_add), 0);
        check("arst_status", int'(game_status), 1);
        check("arst_x", int'(apple_x), 30);
        check("arst_y", int'(apple_y), 15);
        check("arst_type", int'(apple_type), 0);
        repeat (2) cyc();
        rst = 1'b0;
        repeat (3) cyc();
        press();
        tick(30, 15, 1'b0);
        repeat (2) cyc();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
